param_lfsr_prng: RTL and testbench

PARAM_LFSR_PRNG -- requirements
Module: param_lfsr_prng

---
 rtl/param_lfsr_prng.sv | 118 +++++++++++
 tb/tb_param_lfsr_prng.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_lfsr_prng.sv
// Parameterised Fibonacci/Galois LFSR word generator with a valid/ready output.
// Latency: one cycle from an accepted advance to o_valid/o_data.
// Backpressure: while o_valid=1 and i_ready=0, state and output hold regardless of i_en.
module param_lfsr_prng #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int unsigned      MODE  = 1,
  parameter int unsigned      OUT_W = 8,
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_wrap,
  output logic             o_seed_fix
);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("param_lfsr_prng: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("param_lfsr_prng: SEED must be nonzero");
  end
  if (MODE > 1) begin : g_bad_mode
    $error("param_lfsr_prng: MODE must be 0 (Fibonacci) or 1 (Galois)");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_outw
    $error("param_lfsr_prng: OUT_W must be in 1..WIDTH");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("param_lfsr_prng: STEPS must be in 1..WIDTH");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             fix_q, fix_d;
  logic [WIDTH-1:0] adv_state;
  logic             advance;

  // Unrolled chain of STEPS single LFSR shifts starting from the current state.
  always_comb begin
    adv_state = state_q;
    for (int k = 0; k < int'(STEPS); k++) begin
      if (MODE == 0) begin
        adv_state = {adv_state[WIDTH-2:0], ^(adv_state & TAPS)};
      end else begin
        adv_state = (adv_state >> 1) ^ (adv_state[0] ? TAPS : '0);
      end
    end
  end

  // An advance needs enable, no load, and room in the output slot (empty or being consumed).
  assign advance = i_en && !i_load && (!valid_q || i_ready);

  // Next-state selection: load beats advance, advance beats a plain consume.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    data_d  = data_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    fix_d   = 1'b0;
    if (i_load) begin
      // A zero seed would lock the LFSR up, so it is replaced by SEED and flagged.
      if (i_seed == '0) begin
        state_d = SEED;
        seed_d  = SEED;
        fix_d   = 1'b1;
      end else begin
        state_d = i_seed;
        seed_d  = i_seed;
      end
      valid_d = 1'b0;
    end else if (advance) begin
      state_d = adv_state;
      data_d  = adv_state[OUT_W-1:0];
      valid_d = 1'b1;
      wrap_d  = (adv_state == seed_q);
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset drops any pending word immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= SEED;
      seed_q  <= SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      fix_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      fix_q   <= fix_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_wrap     = wrap_q;
  assign o_seed_fix = fix_q;

endmodule

// File: tb/tb_param_lfsr_prng.sv
// Bench for param_lfsr_prng: three configurations driven by one stimulus stream.
// Checks a vector table, hand sequences (wrap, stall, reset) and a random run against a model.
// Model works on whole words with plain arithmetic, one transaction per clock.
module tb_param_lfsr_prng;

  logic        clk = 1'b0;
  logic        arst;
  logic        i_en, i_load, i_ready;
  logic [15:0] i_seed;

  logic [7:0] g_data, f_data, s_data;
  logic       g_valid, f_valid, s_valid;
  logic       g_wrap, f_wrap, s_wrap;
  logic       g_fix, f_fix, s_fix;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults (Galois, 16-bit)
  param_lfsr_prng u_gal (
    .clk(clk), .arst(arst), .i_en(i_en), .i_load(i_load), .i_seed(i_seed),
    .i_ready(i_ready), .o_data(g_data), .o_valid(g_valid), .o_wrap(g_wrap),
    .o_seed_fix(g_fix)
  );

  // Instance 1: 8-bit Fibonacci
  param_lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hDA), .MODE(0)) u_fib (
    .clk(clk), .arst(arst), .i_en(i_en), .i_load(i_load), .i_seed(i_seed[7:0]),
    .i_ready(i_ready), .o_data(f_data), .o_valid(f_valid), .o_wrap(f_wrap),
    .o_seed_fix(f_fix)
  );

  // Instance 2: defaults with two shifts per advance
  param_lfsr_prng #(.STEPS(2)) u_st2 (
    .clk(clk), .arst(arst), .i_en(i_en), .i_load(i_load), .i_seed(i_seed),
    .i_ready(i_ready), .o_data(s_data), .o_valid(s_valid), .o_wrap(s_wrap),
    .o_seed_fix(s_fix)
  );

  // ---------------- reference model ----------------
  int          m_w[3];
  int          m_mode[3];
  int          m_steps[3];
  logic [63:0] m_taps[3];
  logic [63:0] m_init[3];
  logic [63:0] m_state[3];
  logic [63:0] m_aseed[3];
  logic [7:0]  m_data[3];
  logic        m_valid[3];
  logic        m_wrap[3];
  logic        m_fix[3];

  function automatic logic [63:0] one_step(input logic [63:0] s, input int w,
                                           input logic [63:0] taps, input int mode);
    logic [63:0] mask;
    logic [63:0] fb;
    mask = (64'd1 << w) - 64'd1;
    if (mode == 0) begin
      // new LSB is the parity of the tapped bits, everything else moves up one place
      fb = 64'($countones(s & taps) % 2);
      return ((s * 2) + fb) & mask;
    end else begin
      // halve; an odd state folds the tap polynomial back in
      if (s % 2 == 1) return (s / 2) ^ taps;
      else            return s / 2;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_state[i] = m_init[i];
      m_aseed[i] = m_init[i];
      m_data[i]  = 8'h00;
      m_valid[i] = 1'b0;
      m_wrap[i]  = 1'b0;
      m_fix[i]   = 1'b0;
    end
  endtask

  task automatic model_cycle(input logic en, input logic load, input logic ready,
                             input logic [15:0] seed);
    logic [63:0] sv;
    logic [63:0] n;
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = 1'b0;
      m_fix[i]  = 1'b0;
      if (load) begin
        sv = 64'(seed) & ((64'd1 << m_w[i]) - 64'd1);
        if (sv == 0) begin
          sv = m_init[i];
          m_fix[i] = 1'b1;
        end
        m_state[i] = sv;
        m_aseed[i] = sv;
        m_valid[i] = 1'b0;
      end else if (en && (!m_valid[i] || ready)) begin
        n = m_state[i];
        for (int k = 0; k < m_steps[i]; k++) n = one_step(n, m_w[i], m_taps[i], m_mode[i]);
        m_state[i] = n;
        m_data[i]  = n[7:0];
        m_valid[i] = 1'b1;
        m_wrap[i]  = (n == m_aseed[i]);
      end else if (m_valid[i] && ready) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " gal.valid"}, 32'(g_valid), 32'(m_valid[0]));
    chk({tag, " gal.data"},  32'(g_data),  32'(m_data[0]));
    chk({tag, " gal.wrap"},  32'(g_wrap),  32'(m_wrap[0]));
    chk({tag, " gal.fix"},   32'(g_fix),   32'(m_fix[0]));
    chk({tag, " fib.valid"}, 32'(f_valid), 32'(m_valid[1]));
    chk({tag, " fib.data"},  32'(f_data),  32'(m_data[1]));
    chk({tag, " fib.wrap"},  32'(f_wrap),  32'(m_wrap[1]));
    chk({tag, " fib.fix"},   32'(f_fix),   32'(m_fix[1]));
    chk({tag, " st2.valid"}, 32'(s_valid), 32'(m_valid[2]));
    chk({tag, " st2.data"},  32'(s_data),  32'(m_data[2]));
    chk({tag, " st2.wrap"},  32'(s_wrap),  32'(m_wrap[2]));
    chk({tag, " st2.fix"},   32'(s_fix),   32'(m_fix[2]));
  endtask

  // Apply one cycle of stimulus, step the model, sample 1ns after the edge.
  task automatic cycle(input logic en, input logic load, input logic ready,
                       input logic [15:0] seed, input string tag);
    i_en = en; i_load = load; i_ready = ready; i_seed = seed;
    @(posedge clk);
    model_cycle(en, load, ready, seed);
    #1;
    check_all(tag);
  endtask

  // ---------------- vector table for the default instance ----------------
  typedef struct packed {
    logic        en;
    logic        load;
    logic        ready;
    logic [15:0] seed;
    logic        valid;
    logic [7:0]  data;
    logic        wrap;
    logic        fix;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int          wrap_idx[$];
    logic [7:0]  held;
    string       nm;

    m_w     = '{16, 8, 16};
    m_mode  = '{1, 0, 1};
    m_steps = '{1, 1, 2};
    m_taps  = '{64'hB400, 64'hB8, 64'hB400};
    m_init  = '{64'hACE1, 64'hDA, 64'hACE1};

    //            en    load  ready seed      valid data   wrap  fix
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h70, 1'b0, 1'b0}; // ACE1 -> E270
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h38, 1'b0, 1'b0}; // E270 -> 7138
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h38, 1'b0, 1'b0}; // stalled, idle
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h38, 1'b0, 1'b0}; // stalled, en ignored
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h38, 1'b0, 1'b0}; // consumed, no advance
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h9C, 1'b0, 1'b0}; // 7138 -> 389C
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h9C, 1'b0, 1'b1}; // zero load -> SEED
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h70, 1'b0, 1'b0}; // restart from ACE1
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 8'h70, 1'b0, 1'b0}; // load 0001, word dropped
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0}; // 0001 -> B400
    tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0}; // B400 -> 5A00

    // ---- reset state ----
    arst = 1'b1; i_en = 1'b1; i_load = 1'b0; i_ready = 1'b1; i_seed = 16'h0;
    model_reset();
    @(posedge clk);
    #2;
    check_all("reset");
    arst = 1'b0;

    // ---- table run (first row doubles as first-advance-after-release check) ----
    for (int v = 0; v < 11; v++) begin
      nm = $sformatf("tbl%0d", v);
      cycle(tbl[v].en, tbl[v].load, tbl[v].ready, tbl[v].seed, nm);
      chk({nm, " valid"}, 32'(g_valid), 32'(tbl[v].valid));
      chk({nm, " data"},  32'(g_data),  32'(tbl[v].data));
      chk({nm, " wrap"},  32'(g_wrap),  32'(tbl[v].wrap));
      chk({nm, " fix"},   32'(g_fix),   32'(tbl[v].fix));
    end

    // ---- first words of the other configurations, and fix pulse width ----
    arst = 1'b1; #1; arst = 1'b0; model_reset();
    cycle(1'b1, 1'b0, 1'b1, 16'h0, "first");
    chk("fib first data", 32'(f_data), 32'h B5);
    chk("st2 first data", 32'(s_data), 32'h38);
    cycle(1'b1, 1'b1, 1'b1, 16'h0, "zload");
    chk("zload fix gal", 32'(g_fix), 32'd1);
    chk("zload fix fib", 32'(f_fix), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0, "zload+1");
    chk("fix pulse ends", 32'(g_fix), 32'd0);

    // ---- stall for 5 cycles with a word pending ----
    cycle(1'b1, 1'b0, 1'b1, 16'h0, "pre_stall");
    held = g_data;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0, "stall");
      chk("stall data held", 32'(g_data), 32'(held));
      chk("stall valid held", 32'(g_valid), 32'd1);
    end
    cycle(1'b1, 1'b0, 1'b1, 16'h0, "release");
    chk("release new word", 32'(g_data), 32'h38);

    // ---- Fibonacci period: wrap on advance 255 and 510 ----
    arst = 1'b1; #1; arst = 1'b0; model_reset();
    for (int a = 1; a <= 510; a++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'h0, "period");
      if (f_wrap) wrap_idx.push_back(a);
    end
    chk("fib wrap count", 32'(wrap_idx.size()), 32'd2);
    if (wrap_idx.size() >= 2) begin
      chk("fib wrap first", 32'(wrap_idx[0]), 32'd255);
      chk("fib wrap second", 32'(wrap_idx[1]), 32'd510);
    end

    // ---- randomized run against the model ----
    for (int r = 0; r < 2000; r++) begin
      cycle(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 3) != 0,
            (($urandom % 4) == 0) ? 16'h0 : 16'($urandom), "rand");
    end

    // ---- asynchronous reset mid-stream ----
    cycle(1'b1, 1'b0, 1'b0, 16'h0, "pre_arst");
    arst = 1'b1;
    #1;
    model_reset();
    check_all("arst async");
    i_en = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    #1;
    check_all("arst held");
    #2;
    arst = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 16'h0, "post_arst");
    chk("post arst gal data", 32'(g_data), 32'h70);
    chk("post arst fib data", 32'(f_data), 32'hB5);
    chk("post arst st2 data", 32'(s_data), 32'h38);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
